// File: rtl/axil_req_scheduler_if.sv
// Bundle for the two requester command/response ports and the shared AXI4-Lite master port.
// The master modport is the scheduler's view; slave is the environment's view.
interface axil_req_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [ADDR_W-1:0]     req0_addr;
    logic [DATA_W-1:0]     req0_wdata;
    logic [DATA_W/8-1:0]   req0_wstrb;
    logic                  rsp0_valid;
    logic [DATA_W-1:0]     rsp0_rdata;
    logic [1:0]            rsp0_resp;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [ADDR_W-1:0]     req1_addr;
    logic [DATA_W-1:0]     req1_wdata;
    logic [DATA_W/8-1:0]   req1_wstrb;
    logic                  rsp1_valid;
    logic [DATA_W-1:0]     rsp1_rdata;
    logic [1:0]            rsp1_resp;

    logic [ADDR_W-1:0]     m_axi_awaddr;
    logic [2:0]            m_axi_awprot;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;
    logic [DATA_W-1:0]     m_axi_wdata;
    logic [DATA_W/8-1:0]   m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;
    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;
    logic [ADDR_W-1:0]     m_axi_araddr;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [DATA_W-1:0]     m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_resp,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_resp,
        output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid,
        output m_axi_bready,
        output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output m_axi_rready
    );

    modport slave (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_resp,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_resp,
        input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready,
        input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/axil_req_scheduler.sv
// Round-robin scheduler sharing one AXI4-Lite master between two command requesters,
// one transaction in flight, out-of-window addresses answered locally with DECERR.
module axil_req_scheduler #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] WIN_BASE = 32'hA000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 32'h0002_0000
) (
    input logic                  ACLK,
    input logic                  ARESET,
    axil_req_scheduler_if.master bus
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WADDR = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_rr_ptr;
    logic                r_gnt;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic [1:0]          r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata [2];
    logic [1:0]          r_rsp_resp  [2];
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;

    logic [1:0]          w_req_valid;
    logic                w_accept;
    logic                w_gnt;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_in_win;
    logic                w_aw_done;
    logic                w_w_done;

    assign w_req_valid = {bus.req1_valid, bus.req0_valid};
    assign w_accept    = !ARESET && (r_state == IDLE) && (|w_req_valid);
    assign w_gnt       = (&w_req_valid) ? r_rr_ptr : w_req_valid[1];
    assign w_we        = w_gnt ? bus.req1_we    : bus.req0_we;
    assign w_addr      = w_gnt ? bus.req1_addr  : bus.req0_addr;
    assign w_wdata     = w_gnt ? bus.req1_wdata : bus.req0_wdata;
    assign w_wstrb     = w_gnt ? bus.req1_wstrb : bus.req0_wstrb;

    // Offset form cannot overflow even when the window touches the top of the address space.
    assign w_in_win    = (w_addr - WIN_BASE) < WIN_SIZE;

    assign w_aw_done   = !r_awvalid || bus.m_axi_awready;
    assign w_w_done    = !r_wvalid  || bus.m_axi_wready;

    assign bus.req0_ready = w_accept && !w_gnt;
    assign bus.req1_ready = w_accept &&  w_gnt;

    assign bus.m_axi_awaddr  = r_addr;
    assign bus.m_axi_awprot  = 3'b000;
    assign bus.m_axi_awvalid = r_awvalid;
    assign bus.m_axi_wdata   = r_wdata;
    assign bus.m_axi_wstrb   = r_wstrb;
    assign bus.m_axi_wvalid  = r_wvalid;
    assign bus.m_axi_bready  = r_bready;
    assign bus.m_axi_araddr  = r_addr;
    assign bus.m_axi_arprot  = 3'b000;
    assign bus.m_axi_arvalid = r_arvalid;
    assign bus.m_axi_rready  = r_rready;

    assign bus.rsp0_valid = r_rsp_valid[0];
    assign bus.rsp0_rdata = r_rsp_rdata[0];
    assign bus.rsp0_resp  = r_rsp_resp[0];
    assign bus.rsp1_valid = r_rsp_valid[1];
    assign bus.rsp1_rdata = r_rsp_rdata[1];
    assign bus.rsp1_resp  = r_rsp_resp[1];

    // Command payload only matters once granted, so it carries no reset.
    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state        <= IDLE;
            r_rr_ptr       <= 1'b0;
            r_gnt          <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_rsp_valid    <= 2'b00;
            r_rsp_rdata[0] <= '0;
            r_rsp_rdata[1] <= '0;
            r_rsp_resp[0]  <= 2'b00;
            r_rsp_resp[1]  <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gnt    <= w_gnt;
                        r_rr_ptr <= !w_gnt;
                        if (!w_in_win) begin
                            r_rsp_valid[w_gnt] <= 1'b1;
                            r_rsp_rdata[w_gnt] <= '0;
                            r_rsp_resp[w_gnt]  <= 2'b11;
                            r_state            <= RESP;
                        end else if (w_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= WADDR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (r_awvalid && bus.m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && bus.m_axi_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= WRESP;
                    end
                end
                WRESP: begin
                    if (bus.m_axi_bvalid) begin
                        r_bready           <= 1'b0;
                        r_rsp_valid[r_gnt] <= 1'b1;
                        r_rsp_rdata[r_gnt] <= '0;
                        r_rsp_resp[r_gnt]  <= bus.m_axi_bresp;
                        r_state            <= RESP;
                    end
                end
                RADDR: begin
                    if (bus.m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RDATA;
                    end
                end
                RDATA: begin
                    if (bus.m_axi_rvalid) begin
                        r_rready           <= 1'b0;
                        r_rsp_valid[r_gnt] <= 1'b1;
                        r_rsp_rdata[r_gnt] <= bus.m_axi_rdata;
                        r_rsp_resp[r_gnt]  <= bus.m_axi_rresp;
                        r_state            <= RESP;
                    end
                end
                RESP: begin
                    // Single-cycle pulse; response data returns to zero with it.
                    r_rsp_valid    <= 2'b00;
                    r_rsp_rdata[0] <= '0;
                    r_rsp_rdata[1] <= '0;
                    r_rsp_resp[0]  <= 2'b00;
                    r_rsp_resp[1]  <= 2'b00;
                    r_state        <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_req_scheduler.sv
// Bench for axil_req_scheduler: directed scenarios plus randomized two-requester traffic
// against a reference model of grants, window decoding and memory contents.
module tb_axil_req_scheduler;

    localparam logic [31:0] WIN_BASE = 32'hA000_0000;
    localparam logic [31:0] WIN_SIZE = 32'h0002_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_req_scheduler_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axil_req_scheduler #(
        .ADDR_W(32), .DATA_W(32), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
    ) dut (
        .ACLK(clk), .ARESET(rst), .bus(bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- AXI4-Lite slave ----------------
    int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit          rnd_mode = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit          aw_got, w_got, ar_got;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_v;
    logic [3:0]  s_wstrb;
    logic        p_awvalid, p_wvalid, p_bready, p_arvalid, p_rready;
    int          axi_valid_cnt = 0;
    logic [31:0] smem [logic [31:0]];

    always @(negedge clk) begin : slave
        if (rst) begin
            bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
            bus.m_axi_bvalid = 0;  bus.m_axi_rvalid = 0;
            bus.m_axi_bresp = 0;   bus.m_axi_rresp = 0; bus.m_axi_rdata = 0;
            aw_got = 0; w_got = 0; ar_got = 0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            p_awvalid = 0; p_wvalid = 0; p_bready = 0; p_arvalid = 0; p_rready = 0;
        end else begin
            if (p_awvalid && bus.m_axi_awready) begin aw_got = 1; s_awaddr = bus.m_axi_awaddr; end
            if (p_wvalid && bus.m_axi_wready) begin
                w_got = 1; s_wdata = bus.m_axi_wdata; s_wstrb = bus.m_axi_wstrb;
            end
            if (p_arvalid && bus.m_axi_arready) begin ar_got = 1; s_araddr = bus.m_axi_araddr; end
            if (bus.m_axi_bvalid && p_bready) begin
                s_v = smem.exists(s_awaddr) ? smem[s_awaddr] : 32'h0;
                for (int b = 0; b < 4; b++) if (s_wstrb[b]) s_v[8*b +: 8] = s_wdata[8*b +: 8];
                smem[s_awaddr] = s_v;
                bus.m_axi_bvalid = 0; aw_got = 0; w_got = 0; b_cnt = 0;
            end
            if (bus.m_axi_rvalid && p_rready) begin
                bus.m_axi_rvalid = 0; ar_got = 0; r_cnt = 0;
            end

            if (bus.m_axi_awvalid) begin
                bus.m_axi_awready = rnd_mode ? ($urandom_range(0, 2) == 0) : (aw_cnt >= aw_wait);
                aw_cnt++;
            end else begin bus.m_axi_awready = 0; aw_cnt = 0; end
            if (bus.m_axi_wvalid) begin
                bus.m_axi_wready = rnd_mode ? ($urandom_range(0, 2) == 0) : (w_cnt >= w_wait);
                w_cnt++;
            end else begin bus.m_axi_wready = 0; w_cnt = 0; end
            if (bus.m_axi_arvalid) begin
                bus.m_axi_arready = rnd_mode ? ($urandom_range(0, 2) == 0) : (ar_cnt >= ar_wait);
                ar_cnt++;
            end else begin bus.m_axi_arready = 0; ar_cnt = 0; end

            if (aw_got && w_got && !bus.m_axi_bvalid) begin
                if (rnd_mode ? ($urandom_range(0, 2) == 0) : (b_cnt >= b_wait)) begin
                    bus.m_axi_bvalid = 1; bus.m_axi_bresp = cfg_bresp;
                end else b_cnt++;
            end
            if (ar_got && !bus.m_axi_rvalid) begin
                if (rnd_mode ? ($urandom_range(0, 2) == 0) : (r_cnt >= r_wait)) begin
                    bus.m_axi_rvalid = 1; bus.m_axi_rresp = cfg_rresp;
                    bus.m_axi_rdata = smem.exists(s_araddr) ? smem[s_araddr] : 32'h0;
                end else r_cnt++;
            end

            if (bus.m_axi_awvalid || bus.m_axi_wvalid || bus.m_axi_arvalid) axi_valid_cnt++;
            p_awvalid = bus.m_axi_awvalid; p_wvalid = bus.m_axi_wvalid;
            p_bready  = bus.m_axi_bready;  p_arvalid = bus.m_axi_arvalid;
            p_rready  = bus.m_axi_rready;
        end
    end

    // ---------------- reference model and response monitor ----------------
    bit          slave_zw = 1;
    int          cyc = 0;
    int          mptr = 0;
    bit          pend_v = 0;
    int          p_idx, p_gcyc, p_lat;
    logic [31:0] p_rdata;
    logic [1:0]  p_resp;
    logic [31:0] mmem [logic [31:0]];
    int          rsp_cnt [2];
    logic [31:0] last_rdata [2];
    logic [1:0]  last_resp [2];
    int          gnt_log [$];
    int          m_gi, m_ri;
    bit          m_we, m_inwin;
    logic [31:0] m_addr, m_data, m_v;
    logic [3:0]  m_strb;

    always @(negedge clk) begin : monitor
        cyc++;
        if (rst) begin
            mptr = 0; pend_v = 0;
        end else begin
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                m_ri = bus.rsp1_valid ? 1 : 0;
                check_eq("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 0);
                check_eq("rsp_expected", pend_v, 1);
                if (pend_v) begin
                    check_eq("rsp_idx", m_ri, p_idx);
                    check_eq("rsp_rdata", m_ri ? bus.rsp1_rdata : bus.rsp0_rdata, p_rdata);
                    check_eq("rsp_resp", m_ri ? bus.rsp1_resp : bus.rsp0_resp, p_resp);
                    if (p_lat >= 0) check_eq("rsp_latency", cyc - p_gcyc, p_lat);
                end
                check_eq("rsp_other_quiet",
                         m_ri ? {bus.rsp0_rdata, bus.rsp0_resp} : {bus.rsp1_rdata, bus.rsp1_resp}, 0);
                rsp_cnt[m_ri]++;
                last_rdata[m_ri] = m_ri ? bus.rsp1_rdata : bus.rsp0_rdata;
                last_resp[m_ri]  = m_ri ? bus.rsp1_resp  : bus.rsp0_resp;
                pend_v = 0;
            end
            if (bus.req0_ready || bus.req1_ready) begin
                m_gi = bus.req1_ready ? 1 : 0;
                check_eq("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
                check_eq("ready_needs_valid", m_gi ? bus.req1_valid : bus.req0_valid, 1);
                check_eq("grant_while_busy", pend_v, 0);
                check_eq("grant_rr", m_gi,
                         (bus.req0_valid && bus.req1_valid) ? mptr : (bus.req1_valid ? 1 : 0));
                mptr = 1 - m_gi;
                gnt_log.push_back(m_gi);
                m_we   = m_gi ? bus.req1_we    : bus.req0_we;
                m_addr = m_gi ? bus.req1_addr  : bus.req0_addr;
                m_data = m_gi ? bus.req1_wdata : bus.req0_wdata;
                m_strb = m_gi ? bus.req1_wstrb : bus.req0_wstrb;
                m_inwin = ({1'b0, m_addr} >= {1'b0, WIN_BASE}) &&
                          ({1'b0, m_addr} <  ({1'b0, WIN_BASE} + {1'b0, WIN_SIZE}));
                p_idx = m_gi; p_gcyc = cyc;
                if (!m_inwin) begin
                    p_rdata = 0; p_resp = 2'b11; p_lat = 1;
                end else if (m_we) begin
                    m_v = mmem.exists(m_addr) ? mmem[m_addr] : 32'h0;
                    for (int b = 0; b < 4; b++) if (m_strb[b]) m_v[8*b +: 8] = m_data[8*b +: 8];
                    mmem[m_addr] = m_v;
                    p_rdata = 0; p_resp = cfg_bresp; p_lat = slave_zw ? 3 : -1;
                end else begin
                    p_rdata = mmem.exists(m_addr) ? mmem[m_addr] : 32'h0;
                    p_resp = cfg_rresp; p_lat = slave_zw ? 3 : -1;
                end
                pend_v = 1;
            end
        end
    end

    // ---------------- requester driving ----------------
    task automatic issue(input int idx, input bit we, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb);
        bit got = 0;
        if (idx == 0) begin
            bus.req0_valid = 1; bus.req0_we = we; bus.req0_addr = addr;
            bus.req0_wdata = data; bus.req0_wstrb = strb;
        end else begin
            bus.req1_valid = 1; bus.req1_we = we; bus.req1_addr = addr;
            bus.req1_wdata = data; bus.req1_wstrb = strb;
        end
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (idx == 0 ? bus.req0_ready : bus.req1_ready) got = 1;
        end
        if (!got) check_eq("issue_timeout", idx == 0 ? bus.req0_ready : bus.req1_ready, 1);
        @(posedge clk); #1;
        if (idx == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400 && pend_v; k++) begin @(posedge clk); #1; end
        check_eq("done_timeout", pend_v, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'hA000_0000;
            1:       return 32'hA001_FFFC;
            2:       return 32'hA002_0000 + 4 * $urandom_range(0, 3);
            3:       return 32'h9FFF_FFFC;
            4:       return $urandom & 32'hFFFF_FFFC;
            default: return 32'hA001_0000 + 4 * $urandom_range(0, 15);
        endcase
    endfunction

    task automatic rand_stream(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue(idx, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 4'($urandom_range(1, 15)));
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    int c0;

    initial begin : main
        bus.req0_valid = 0; bus.req0_we = 0; bus.req0_addr = 0; bus.req0_wdata = 0; bus.req0_wstrb = 0;
        bus.req1_valid = 0; bus.req1_we = 0; bus.req1_addr = 0; bus.req1_wdata = 0; bus.req1_wstrb = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;

        // Reset state, including a requester pushing during reset.
        #1 bus.req0_valid = 1;
        #1;
        check_eq("rst_ready0", bus.req0_ready, 0);
        check_eq("rst_axi_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid,
                                    bus.m_axi_bready, bus.m_axi_rready}, 0);
        check_eq("rst_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata,
                             bus.rsp0_resp, bus.rsp1_resp}, 0);
        bus.req0_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Plan 1: zero-wait write from requester 0.
        issue(0, 1, 32'hA000_0000, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        check_eq("t1_awvalid_T1", bus.m_axi_awvalid, 1);
        check_eq("t1_wvalid_T1", bus.m_axi_wvalid, 1);
        check_eq("t1_awaddr", bus.m_axi_awaddr, 32'hA000_0000);
        check_eq("t1_wdata", bus.m_axi_wdata, 32'hFFFF_FFFF);
        @(negedge clk);
        check_eq("t1_bready_T2", bus.m_axi_bready, 1);
        @(negedge clk);
        check_eq("t1_rsp0_T3", bus.rsp0_valid, 1);
        check_eq("t1_resp", bus.rsp0_resp, 0);
        check_eq("t1_no_rsp1", bus.rsp1_valid, 0);
        wait_done();

        // Plan 2: write then read back via requester 1.
        issue(1, 1, 32'hA001_0000, 32'hDEAD_BEEF, 4'hF);
        wait_done();
        issue(1, 0, 32'hA001_0000, 32'h0, 4'h0);
        wait_done();
        check_eq("t2_rdata", last_rdata[1], 32'hDEAD_BEEF);
        check_eq("t2_resp", last_resp[1], 0);

        // Plan 3: both requesters continuously valid from reset.
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        gnt_log.delete(); rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        fork
            for (int i = 0; i < 3; i++) issue(0, 1, 32'hA001_0100 + 4 * i, 32'h100 + i, 4'hF);
            for (int i = 0; i < 3; i++) issue(1, 0, 32'hA001_0100 + 4 * i, 32'h0, 4'h0);
        join
        wait_done();
        check_eq("t3_ngrants", gnt_log.size(), 6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++) check_eq($sformatf("t3_grant%0d", i), gnt_log[i], i % 2);
        check_eq("t3_rsp0_cnt", rsp_cnt[0], 3);
        check_eq("t3_rsp1_cnt", rsp_cnt[1], 3);

        // Plan 4: window edges.
        c0 = axi_valid_cnt;
        issue(0, 0, 32'hA002_0000, 32'h0, 4'h0);
        wait_done();
        check_eq("t4_err_resp", last_resp[0], 2'b11);
        check_eq("t4_err_rdata", last_rdata[0], 0);
        issue(1, 1, 32'h9FFF_FFFC, 32'h1234_5678, 4'hF);
        wait_done();
        check_eq("t4_err_resp_w", last_resp[1], 2'b11);
        check_eq("t4_no_axi", axi_valid_cnt, c0);
        issue(0, 0, 32'hA001_FFFC, 32'h0, 4'h0);
        wait_done();
        check_eq("t4_edge_ok", last_resp[0], 2'b00);
        check_eq("t4_edge_axi", axi_valid_cnt > c0, 1);

        // Plan 5: W accepted before AW, slow SLVERR write response.
        aw_wait = 3; b_wait = 5; cfg_bresp = 2'b10; slave_zw = 0;
        issue(0, 1, 32'hA001_0004, 32'h1234_5678, 4'hF);
        @(negedge clk);
        check_eq("t5_both_valid", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b11);
        @(negedge clk);
        check_eq("t5_w_first", {bus.m_axi_awvalid, bus.m_axi_wvalid}, 2'b10);
        for (int k = 0; k < 50 && bus.m_axi_awvalid; k++) @(negedge clk);
        for (int k = 0; k < 50 && !bus.rsp0_valid; k++) begin
            check_eq("t5_bready_held", bus.m_axi_bready, 1);
            @(negedge clk);
        end
        check_eq("t5_rsp", bus.rsp0_valid, 1);
        check_eq("t5_resp", bus.rsp0_resp, 2'b10);
        wait_done();
        aw_wait = 0; b_wait = 0; cfg_bresp = 2'b00; slave_zw = 1;

        // Plan 6: asynchronous reset while waiting for read data.
        r_wait = 10; slave_zw = 0;
        issue(0, 0, 32'hA000_0000, 32'h0, 4'h0);
        for (int k = 0; k < 50 && !bus.m_axi_rready; k++) @(negedge clk);
        check_eq("t6_in_rdata", bus.m_axi_rready, 1);
        #1 rst = 1;
        #1;
        check_eq("t6_rready", bus.m_axi_rready, 0);
        check_eq("t6_arvalid", bus.m_axi_arvalid, 0);
        check_eq("t6_rsp", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_rdata, bus.rsp1_rdata,
                            bus.rsp0_resp, bus.rsp1_resp}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        r_wait = 0; slave_zw = 1;
        gnt_log.delete();
        fork
            issue(0, 0, 32'hA001_0000, 32'h0, 4'h0);
            issue(1, 0, 32'hA000_0000, 32'h0, 4'h0);
        join
        wait_done();
        check_eq("t6_first_grant", gnt_log.size() > 0 ? gnt_log[0] : -1, 0);
        check_eq("t6_rdata_after", last_rdata[0], 32'hDEAD_BEEF);

        // Randomized traffic from both requesters against a random-latency slave.
        rnd_mode = 1; slave_zw = 0;
        fork
            rand_stream(0, 80);
            rand_stream(1, 80);
        join
        wait_done();
        rnd_mode = 0; slave_zw = 1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axil_req_scheduler.md
Name: axil_req_scheduler

Overview:
- Shares one AXI4-Lite master port between two simple command requesters, e.g. a PS-side sequencer and a PL self-test engine.
- The master port drives the LED GPIO (0xA0000000) and the BRAM controller (0xA0010000) through the existing interconnect.
- Arbitration is round-robin with a single outstanding transaction.
- Addresses outside the legal window are rejected locally with DECERR; no AXI traffic is issued for them.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (32 only)
WIN_BASE, 32'hA000_0000, lowest legal address
WIN_SIZE, 32'h0002_0000, window size in bytes; legal when WIN_BASE <= addr < WIN_BASE+WIN_SIZE

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
reqN_valid  in  1  command valid (N = 0,1; all reqN_/rspN_ ports exist for both requesters)
reqN_ready  out  1  command accepted this cycle
reqN_we  in  1  1 = write, 0 = read
reqN_addr  in  ADDR_W  byte address, word aligned
reqN_wdata  in  DATA_W  write data
reqN_wstrb  in  DATA_W/8  write strobes
rspN_valid  out  1  one-cycle completion pulse
rspN_rdata  out  DATA_W  read data (0 for writes and errors)
rspN_resp  out  2  AXI response code
m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready  standard AXI4-Lite master; awprot/arprot tied to 3'b000

Behaviour:
- Reset values: every valid/ready output 0, rspN_rdata 0, rspN_resp 0, state IDLE, rr_ptr 0 (requester 0 preferred).
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE grant:
  - If exactly one reqN_valid is high, that requester is granted.
  - If both are high, the rr_ptr requester is granted.
  - reqN_ready is asserted combinationally in the grant cycle.
  - The command and the granted index are latched; rr_ptr becomes the other index.
  - reqN_ready is 0 in every state other than IDLE.
- Address out of window: go to RESP with resp 2'b11 and rdata 0. No AXI valid is raised.
- Write in window: go to WADDR.
  - awvalid and wvalid rise together on the next cycle.
  - Each drops independently after its own handshake. AW-before-W, W-before-AW and simultaneous acceptance are all legal.
  - Once both are done, go to WRESP with bready = 1.
  - On the bvalid handshake, capture bresp and go to RESP.
- Read in window: go to RADDR with arvalid.
  - After the arready handshake, go to RDATA with rready = 1.
  - On the rvalid handshake, capture rdata and rresp, then go to RESP.
- RESP: lasts exactly one cycle.
  - rspG_valid = 1 for the granted requester only; the other requester's rsp outputs stay at 0.
  - Return to IDLE. The next grant is possible in the cycle after RESP.
- Valids are never withdrawn before their handshake. Address, data and strobe outputs are held stable while valid.
- Minimum latency with a zero-wait slave:
  - Write: accept at T0, aw/w at T1, b at T2, rsp at T3.
  - Read: accept at T0, ar at T1, r at T2, rsp at T3.
  - Decode error: rsp at T1.
- Window edge: the upper bound is exclusive (WIN_BASE+WIN_SIZE is illegal). The computation must not overflow: compare (addr - WIN_BASE) < WIN_SIZE as unsigned.
- Reset mid-transaction: the asynchronous reset returns all outputs to reset values immediately. The in-flight command is dropped and no response is generated. Slave-side cleanup is the interconnect's reset responsibility.
- Requester dropping valid before ready: legal, nothing is latched.

Test Plan:
1. Req0 writes 0xFFFFFFFF to 0xA0000000, zero-wait slave -> awvalid and wvalid at T1, rsp0_valid at T3 with resp 2'b00; no rsp1 pulse.
2. Req1 writes 0xDEADBEEF to 0xA0010000, then reads it back -> rsp1_rdata 0xDEADBEEF, resp 2'b00.
3. Both requesters valid every cycle for 6 transactions -> grants alternate 0,1,0,1,0,1 from reset; each requester receives exactly 3 responses.
4. Read of 0xA0020000 and write to 0x9FFFFFFC -> rsp at T1 with resp 2'b11 and rdata 0; no AXI valid ever asserted. Read of 0xA001FFFC -> normal AXI read.
5. Slave gives wready 3 cycles before awready, then bvalid after 5 wait cycles with bresp 2'b10 -> wvalid drops first, bready held throughout, rsp resp 2'b10.
6. ARESET asserted while in RDATA -> rready, arvalid and all rsp outputs go to 0 asynchronously. After release, a req0 read completes normally with rr_ptr = 0.
